// File: rtl/pixy_bus_pkg.sv
// Shared bus-side definitions for the 68000 cycle terminator: the tracking
// state encoding, default timing constants and the counter sizing helper.
package pixy_bus_pkg;

  // Bus-cycle tracking states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ACK   = 2'd2,
    BERR  = 2'd3
  } bus_state_t;

  // Zero wait states by default; 64 CPU clocks before declaring a bus error.
  localparam int DEFAULT_WAIT_CYCLES    = 0;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_SYNC_STAGES    = 2;

  // Bits needed to hold 0..max_count inclusive; never narrower than 1 bit.
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/dtack_generator_if.sv
// CPU-side bus signals seen by the cycle terminator. The master modport is
// the CPU/decoder side, the slave modport is the terminator itself.
interface dtack_generator_if;

  logic CPU_CLK;    // divided CPU clock, already registered in CLK_IN domain
  logic AS_N;       // address strobe, asynchronous
  logic SEL;        // chip-select decode, asynchronous, high = claimed
  logic DTACK_N;    // data transfer acknowledge
  logic BERR_N;     // bus error
  logic BUSY;       // a bus cycle is being tracked
  logic CYCLE_END;  // one-clock pulse when a cycle closes

  modport master (
    output CPU_CLK,
    output AS_N,
    output SEL,
    input  DTACK_N,
    input  BERR_N,
    input  BUSY,
    input  CYCLE_END
  );

  modport slave (
    input  CPU_CLK,
    input  AS_N,
    input  SEL,
    output DTACK_N,
    output BERR_N,
    output BUSY,
    output CYCLE_END
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit. The reset value is
// a parameter so an idle bus level can be presented straight out of reset.
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First flop samples the asynchronous input.
        always_ff @(posedge CLK_IN or negedge RST_N) begin
          if (!RST_N) begin
            stage_reg[0] <= RESET_VAL;
          end else begin
            stage_reg[0] <= d;
          end
        end
      end else begin : g_rest
        // Later flops give the first one time to resolve metastability.
        always_ff @(posedge CLK_IN or negedge RST_N) begin
          if (!RST_N) begin
            stage_reg[gi] <= RESET_VAL;
          end else begin
            stage_reg[gi] <= stage_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/dtack_generator.sv
// 68000 bus-cycle terminator. Tracks each address-strobe cycle, acknowledges
// it with DTACK_N after WAIT_CYCLES CPU clock falling edges with the device
// selected, or terminates it with BERR_N if nothing selects within
// TIMEOUT_CYCLES falling edges. TIMEOUT_CYCLES must exceed WAIT_CYCLES.
module dtack_generator
  import pixy_bus_pkg::*;
#(
  parameter int WAIT_CYCLES    = DEFAULT_WAIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
  input  logic               CLK_IN,
  input  logic               RST_N,
  dtack_generator_if.slave   bus
);

  localparam int              CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WAIT_CMP = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] TOUT_CMP = CNT_W'(TIMEOUT_CYCLES);

  // Synchronized strobe and select; every decision below uses only these.
  logic as_s;
  logic sel_s;

  // CPU_CLK is already in this clock domain, so a single delay flop is
  // enough to find its falling edge.
  logic cpu_clk_q;
  logic fall_evt;

  bus_state_t       state_reg, state_next;
  logic [CNT_W-1:0] wcnt_reg, wcnt_next;
  logic [CNT_W-1:0] tcnt_reg, tcnt_next;
  logic             dtack_n_reg, dtack_n_next;
  logic             berr_n_reg, berr_n_next;
  logic             busy_reg, busy_next;
  logic             cycle_end_reg, cycle_end_next;

  // Strobe idles high so a reset never looks like the start of a cycle.
  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_as_sync (
    .CLK_IN (CLK_IN),
    .RST_N  (RST_N),
    .d      (bus.AS_N),
    .q      (as_s)
  );

  // Select idles low: nothing claims the bus until the decoder says so.
  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sel_sync (
    .CLK_IN (CLK_IN),
    .RST_N  (RST_N),
    .d      (bus.SEL),
    .q      (sel_s)
  );

  // Remember last CPU_CLK level for falling-edge detection.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      cpu_clk_q <= 1'b0;
    end else begin
      cpu_clk_q <= bus.CPU_CLK;
    end
  end

  assign fall_evt = cpu_clk_q & ~bus.CPU_CLK;

  // State, counters and registered outputs; reset negates outputs at once,
  // even in the middle of an acknowledged cycle.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      wcnt_reg      <= '0;
      tcnt_reg      <= '0;
      dtack_n_reg   <= 1'b1;
      berr_n_reg    <= 1'b1;
      busy_reg      <= 1'b0;
      cycle_end_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wcnt_reg      <= wcnt_next;
      tcnt_reg      <= tcnt_next;
      dtack_n_reg   <= dtack_n_next;
      berr_n_reg    <= berr_n_next;
      busy_reg      <= busy_next;
      cycle_end_reg <= cycle_end_next;
    end
  end

  // Next-state and next-output decode; abort beats ack beats bus error.
  always_comb begin
    state_next     = state_reg;
    wcnt_next      = wcnt_reg;
    tcnt_next      = tcnt_reg;
    dtack_n_next   = dtack_n_reg;
    berr_n_next    = berr_n_reg;
    busy_next      = busy_reg;
    cycle_end_next = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_next    = 1'b0;
        dtack_n_next = 1'b1;
        berr_n_next  = 1'b1;
        if (!as_s) begin
          state_next = COUNT;
          busy_next  = 1'b1;
          wcnt_next  = '0;
          tcnt_next  = '0;
        end
      end

      COUNT: begin
        // Wait counter runs while selected, timeout counter while not;
        // both stick at full scale rather than wrapping.
        if (fall_evt) begin
          if (sel_s && (wcnt_reg != CNT_MAX)) begin
            wcnt_next = wcnt_reg + 1'b1;
          end
          if (!sel_s && (tcnt_reg != CNT_MAX)) begin
            tcnt_next = tcnt_reg + 1'b1;
          end
        end

        if (as_s) begin
          state_next     = IDLE;
          busy_next      = 1'b0;
          cycle_end_next = 1'b1;
        end else if (sel_s && (wcnt_reg >= WAIT_CMP)) begin
          state_next   = ACK;
          dtack_n_next = 1'b0;
        end else if (!sel_s && (tcnt_reg >= TOUT_CMP)) begin
          state_next  = BERR;
          berr_n_next = 1'b0;
        end
      end

      ACK: begin
        // Select may drop here; the acknowledge holds until the strobe ends.
        if (as_s) begin
          state_next     = IDLE;
          dtack_n_next   = 1'b1;
          busy_next      = 1'b0;
          cycle_end_next = 1'b1;
        end
      end

      BERR: begin
        if (as_s) begin
          state_next     = IDLE;
          berr_n_next    = 1'b1;
          busy_next      = 1'b0;
          cycle_end_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.DTACK_N   = dtack_n_reg;
  assign bus.BERR_N    = berr_n_reg;
  assign bus.BUSY      = busy_reg;
  assign bus.CYCLE_END = cycle_end_reg;

endmodule

// File: tb/tb_dtack_generator.sv
// Scoreboard bench for dtack_generator. Three instances with different wait
// and timeout settings share one clock, reset and CPU_CLK. Stimulus pushes
// expected output events (edge kind, instance, CLK_IN edge number) into a
// queue; a monitor on the falling CLK_IN edge pops and compares every
// DTACK_N/BERR_N transition and CYCLE_END pulse it observes.
module tb_dtack_generator;

  localparam int EV_DT_FALL = 0;
  localparam int EV_DT_RISE = 1;
  localparam int EV_BE_FALL = 2;
  localparam int EV_BE_RISE = 3;
  localparam int EV_CE      = 4;

  typedef struct {
    int inst;
    int kind;
    int cyc;
  } ev_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic cpu_clk = 1'b1;
  int   cyc     = 0;
  int   compared   = 0;
  int   mismatched = 0;
  ev_t  exp_q[$];

  dtack_generator_if if_a ();
  dtack_generator_if if_b ();
  dtack_generator_if if_c ();

  // A: zero wait, short timeout.  B: two wait states.  C: three wait states.
  dtack_generator #(.WAIT_CYCLES(0), .TIMEOUT_CYCLES(4),  .SYNC_STAGES(2)) dut_a (
    .CLK_IN(clk), .RST_N(rst_n), .bus(if_a));
  dtack_generator #(.WAIT_CYCLES(2), .TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut_b (
    .CLK_IN(clk), .RST_N(rst_n), .bus(if_b));
  dtack_generator #(.WAIT_CYCLES(3), .TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut_c (
    .CLK_IN(clk), .RST_N(rst_n), .bus(if_c));

  assign if_a.CPU_CLK = cpu_clk;
  assign if_b.CPU_CLK = cpu_clk;
  assign if_c.CPU_CLK = cpu_clk;

  logic cur_dt[3];
  logic cur_be[3];
  logic cur_ce[3];
  assign cur_dt[0] = if_a.DTACK_N;
  assign cur_dt[1] = if_b.DTACK_N;
  assign cur_dt[2] = if_c.DTACK_N;
  assign cur_be[0] = if_a.BERR_N;
  assign cur_be[1] = if_b.BERR_N;
  assign cur_be[2] = if_c.BERR_N;
  assign cur_ce[0] = if_a.CYCLE_END;
  assign cur_ce[1] = if_b.CYCLE_END;
  assign cur_ce[2] = if_c.CYCLE_END;

  always #5 clk = ~clk;

  // cyc = number of rising CLK_IN edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // CPU_CLK: period 80 CLK_IN, driven just after an edge. It goes low after
  // edges with cyc%80==40, so the falling-edge counters step on edge cyc+1.
  always @(posedge clk) begin
    #1;
    cpu_clk = ((cyc % 80) < 40);
  end

  function automatic string kind_name(input int k);
    case (k)
      EV_DT_FALL: return "dtack_fall";
      EV_DT_RISE: return "dtack_rise";
      EV_BE_FALL: return "berr_fall";
      EV_BE_RISE: return "berr_rise";
      EV_CE:      return "cycle_end";
      default:    return "unknown";
    endcase
  endfunction

  task automatic expect_ev(input int inst, input int kind, input int c);
    ev_t e;
    e.inst = inst;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int inst, input int kind);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL event: got dut%0d %s at edge %0d, required no event",
               inst, kind_name(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.kind != kind || e.cyc != cyc) begin
        mismatched++;
        $display("FAIL event: got dut%0d %s at edge %0d, required dut%0d %s at edge %0d",
                 inst, kind_name(kind), cyc, e.inst, kind_name(e.kind), e.cyc);
      end else begin
        $display("ok   event: dut%0d %s at edge %0d", inst, kind_name(kind), cyc);
      end
    end
  endtask

  task automatic check(input string name, input logic actual, input logic req);
    compared++;
    if (actual !== req) begin
      mismatched++;
      $display("FAIL %s: got %b, required %b (edge %0d)", name, actual, req, cyc);
    end else begin
      $display("ok   %s = %b (edge %0d)", name, actual, cyc);
    end
  endtask

  // Advance to 1 time unit after rising edge n.
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Next edge number aligned to the CPU_CLK period.
  function automatic int next_aligned(input int c);
    return ((c / 80) + 1) * 80;
  endfunction

  // Monitor: one event per observed transition, compared against the queue.
  logic prev_dt[3];
  logic prev_be[3];
  initial begin
    for (int i = 0; i < 3; i++) begin
      prev_dt[i] = 1'b1;
      prev_be[i] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (cur_dt[i] !== prev_dt[i]) observe(i, (cur_dt[i] === 1'b1) ? EV_DT_RISE : EV_DT_FALL);
        if (cur_be[i] !== prev_be[i]) observe(i, (cur_be[i] === 1'b1) ? EV_BE_RISE : EV_BE_FALL);
        if (cur_ce[i] === 1'b1) observe(i, EV_CE);
        if (cur_dt[i] === 1'b0 || cur_be[i] === 1'b0) begin
          compared++;
          if (cur_dt[i] === 1'b0 && cur_be[i] === 1'b0) begin
            mismatched++;
            $display("FAIL exclusive: dut%0d DTACK_N=0 BERR_N=0 at edge %0d, required not both low",
                     i, cyc);
          end
        end
        prev_dt[i] = cur_dt[i];
        prev_be[i] = cur_be[i];
      end
    end
  end

  // Stimulus.
  initial begin
    int t;
    int r;
    if_a.AS_N = 1'b1; if_a.SEL = 1'b0;
    if_b.AS_N = 1'b1; if_b.SEL = 1'b0;
    if_c.AS_N = 1'b1; if_c.SEL = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_a_dtack", if_a.DTACK_N, 1'b1);
    check("rst_a_berr",  if_a.BERR_N,  1'b1);
    check("rst_a_busy",  if_a.BUSY,    1'b0);
    check("rst_a_cend",  if_a.CYCLE_END, 1'b0);
    check("rst_b_dtack", if_b.DTACK_N, 1'b1);
    check("rst_b_berr",  if_b.BERR_N,  1'b1);
    check("rst_b_busy",  if_b.BUSY,    1'b0);
    check("rst_b_cend",  if_b.CYCLE_END, 1'b0);
    check("rst_c_dtack", if_c.DTACK_N, 1'b1);
    check("rst_c_berr",  if_c.BERR_N,  1'b1);
    check("rst_c_busy",  if_c.BUSY,    1'b0);
    check("rst_c_cend",  if_c.CYCLE_END, 1'b0);
    step_to(3);
    rst_n = 1'b0;
    rst_n = 1'b1;

    // 1: zero-wait latency, SEL stable high.
    if_a.SEL = 1'b1;
    step_to(10);
    t = cyc;
    if_a.AS_N = 1'b0;
    expect_ev(0, EV_DT_FALL, t + 4);
    step_to(t + 50);
    check("s1_busy_high", if_a.BUSY, 1'b1);
    step_to(t + 100);
    if_a.AS_N = 1'b1;
    expect_ev(0, EV_DT_RISE, t + 103);
    expect_ev(0, EV_CE,      t + 103);
    step_to(t + 104);
    check("s1_busy_low", if_a.BUSY, 1'b0);

    // 1b: back-to-back cycles keep a BUSY low gap.
    step_to(cyc + 5);
    t = cyc;
    if_a.AS_N = 1'b0;
    expect_ev(0, EV_DT_FALL, t + 4);
    step_to(t + 30);
    if_a.AS_N = 1'b1;
    step_to(t + 31);
    if_a.AS_N = 1'b0;
    expect_ev(0, EV_DT_RISE, t + 33);
    expect_ev(0, EV_CE,      t + 33);
    expect_ev(0, EV_DT_FALL, t + 35);
    step_to(t + 33);
    check("b2b_busy_gap", if_a.BUSY, 1'b0);
    step_to(t + 34);
    check("b2b_busy_again", if_a.BUSY, 1'b1);
    step_to(t + 60);
    if_a.AS_N = 1'b1;
    expect_ev(0, EV_DT_RISE, t + 63);
    expect_ev(0, EV_CE,      t + 63);

    // 3: timeout of 4 falling edges with SEL low gives BERR_N.
    if_a.SEL = 1'b0;
    step_to(next_aligned(cyc + 10));
    t = cyc;
    if_a.AS_N = 1'b0;
    expect_ev(0, EV_BE_FALL, t + 282);
    step_to(t + 300);
    if_a.AS_N = 1'b1;
    expect_ev(0, EV_BE_RISE, t + 303);
    expect_ev(0, EV_CE,      t + 303);

    // 6: SEL arrives on the same edge the timeout count is reached.
    step_to(next_aligned(cyc + 10));
    t = cyc;
    if_a.AS_N = 1'b0;
    step_to(t + 279);
    if_a.SEL = 1'b1;
    expect_ev(0, EV_DT_FALL, t + 282);
    step_to(t + 300);
    if_a.AS_N = 1'b1;
    expect_ev(0, EV_DT_RISE, t + 303);
    expect_ev(0, EV_CE,      t + 303);

    // 2: two wait states, ack one edge after the 2nd falling edge counts.
    if_b.SEL = 1'b1;
    step_to(next_aligned(cyc + 10));
    t = cyc;
    if_b.AS_N = 1'b0;
    expect_ev(1, EV_DT_FALL, t + 122);
    step_to(t + 200);
    if_b.AS_N = 1'b1;
    expect_ev(1, EV_DT_RISE, t + 203);
    expect_ev(1, EV_CE,      t + 203);

    // 4: strobe withdrawn before the wait completes.
    if_c.SEL = 1'b1;
    step_to(next_aligned(cyc + 10));
    t = cyc;
    if_c.AS_N = 1'b0;
    step_to(t + 60);
    if_c.AS_N = 1'b1;
    expect_ev(2, EV_CE, t + 63);

    // 5: reset in the middle of an acknowledged cycle.
    step_to(cyc + 10);
    t = cyc;
    if_a.AS_N = 1'b0;
    expect_ev(0, EV_DT_FALL, t + 4);
    step_to(t + 20);
    expect_ev(0, EV_DT_RISE, t + 20);
    rst_n = 1'b0;
    #2;
    check("rst_mid_dtack", if_a.DTACK_N, 1'b1);
    check("rst_mid_busy",  if_a.BUSY,    1'b0);
    step_to(t + 22);
    r = cyc;
    rst_n = 1'b1;
    expect_ev(0, EV_DT_FALL, r + 4);
    step_to(r + 20);
    if_a.AS_N = 1'b1;
    expect_ev(0, EV_DT_RISE, r + 23);
    expect_ev(0, EV_CE,      r + 23);
    step_to(r + 40);

    // Anything still queued never happened.
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL event: got nothing, required dut%0d %s at edge %0d",
               e.inst, kind_name(e.kind), e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dtack_generator.md
Name: dtack_generator

Overview:
- Bus-cycle terminator for the 68000, directly downstream of the CPU clock divider.
- Runs on the 40 MHz FPGA clock and takes the divided CPU_CLK as a same-domain registered signal.
- Watches AS_N and the external chip-select decode, then drives DTACK_N after a programmable number of CPU_CLK falling edges.
- Drives BERR_N instead if no device selects within a timeout.

Parameters:
- WAIT_CYCLES, 0: CPU_CLK falling edges to count after strobe detection before DTACK_N asserts.
- TIMEOUT_CYCLES, 64: CPU_CLK falling edges with SEL low before BERR_N asserts. Must be > WAIT_CYCLES.
- SYNC_STAGES, 2: synchronizer depth on AS_N and SEL.

Ports:
- CLK_IN  in  1  40 MHz FPGA clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- CPU_CLK  in  1  divided CPU clock, registered in the CLK_IN domain.
- AS_N  in  1  68000 address strobe; asynchronous to CLK_IN.
- SEL  in  1  chip-select decode for the current address, high = some device claims it; asynchronous.
- DTACK_N  out  1  data transfer acknowledge to the CPU; registered.
- BERR_N  out  1  bus error to the CPU; registered.
- BUSY  out  1  high while a bus cycle is being tracked.
- CYCLE_END  out  1  one-CLK_IN pulse when a cycle closes.

Behaviour:
- Reset (async, RST_N=0):
  - DTACK_N=1, BERR_N=1, BUSY=0, CYCLE_END=0.
  - State IDLE; counters 0; synchronizers preset to AS_N=1, SEL=0; cpu_clk_q=0.
  - Outputs negate immediately, including when reset hits mid-cycle.
- Edge detect: cpu_clk_q <= CPU_CLK. fall_evt = cpu_clk_q & ~CPU_CLK, a single CLK_IN pulse. CPU_CLK is not synchronized.
- Synchronization: as_s and sel_s are the outputs of SYNC_STAGES flops. All decisions use as_s and sel_s only.
- Counters:
  - wcnt and tcnt are sized $clog2(TIMEOUT_CYCLES+1) bits and saturate at their maximum.
  - Both clear on entry to COUNT.
- State machine (registered outputs update on the same edge as the state transition):
  - IDLE: BUSY=0. If as_s==0, go to COUNT and set BUSY=1.
  - COUNT:
    - If as_s==1 (aborted cycle), go to IDLE with CYCLE_END=1; no DTACK_N or BERR_N.
    - Else if sel_s==1 and wcnt>=WAIT_CYCLES, go to ACK with DTACK_N=0.
    - Else if sel_s==0 and tcnt>=TIMEOUT_CYCLES, go to BERR with BERR_N=0.
    - On fall_evt: wcnt++ when sel_s==1, tcnt++ when sel_s==0.
    - With WAIT_CYCLES=0, ACK is entered on the first COUNT cycle in which sel_s==1.
  - ACK: hold DTACK_N=0 until as_s==1, then go to IDLE with DTACK_N=1, BUSY=0 and CYCLE_END=1.
  - BERR: same as ACK, but for BERR_N.
- Priority within COUNT: abort > ack > berr. DTACK_N and BERR_N are never low together.
- Latency (WAIT_CYCLES=0, SEL already stable):
  - AS_N fall to DTACK_N low = SYNC_STAGES+2 CLK_IN edges (sync, IDLE→COUNT, COUNT→ACK).
  - AS_N rise to DTACK_N high = SYNC_STAGES+1 edges.
- Back-to-back cycles: after returning to IDLE, a new AS_N low re-enters COUNT no earlier than the next edge. BUSY must show a low cycle between bus cycles.
- SEL dropping while in ACK has no effect; DTACK_N holds until AS_N negates.

Decomposition:
- Shared package pixy_bus_pkg holds:
  - state enum: IDLE, COUNT, ACK, BERR, 2-bit encoding;
  - default WAIT_CYCLES and TIMEOUT_CYCLES constants;
  - the counter-width function.
- One sub-module: bit_synchronizer (parameterised depth and reset value), instantiated for AS_N and SEL.

Test Plan:
- WAIT_CYCLES=0, SYNC_STAGES=2, SEL=1, AS_N falls at cycle t → DTACK_N low at edge t+4. AS_N rises at t+100 → DTACK_N high at t+103, with a CYCLE_END pulse at t+103.
- WAIT_CYCLES=2, CPU_CLK at period 80 CLK_IN, SEL=1 → DTACK_N low exactly one CLK_IN after the 2nd CPU_CLK falling edge following COUNT entry; BERR_N stays 1.
- TIMEOUT_CYCLES=4, SEL=0 → BERR_N low one CLK_IN after the 4th falling edge; DTACK_N stays 1; BERR_N high 3 edges after AS_N rises.
- Abort: WAIT_CYCLES=3, AS_N rises after 1 falling edge → return to IDLE; DTACK_N and BERR_N never assert; CYCLE_END pulses once.
- Reset mid-ACK: RST_N=0 while DTACK_N=0 → DTACK_N=1 and BUSY=0 asynchronously before the next CLK_IN. After release with AS_N still low, a fresh cycle starts and DTACK_N reasserts per the latency rules.
- Simultaneous: SEL rises on the same edge tcnt reaches TIMEOUT_CYCLES → DTACK_N asserts and BERR_N stays 1.
